// File: rtl/tb_ahb_sim_ctrl_if.sv
// Snooped AHB-Lite write bus plus the console valid/ready sink, shared by the
// simulation controller (slave side) and whoever drives the bus (master side).
interface tb_ahb_sim_ctrl_if;
  logic [1:0]  htrans;
  logic [31:0] haddr;
  logic        hwrite;
  logic [31:0] hwdata;
  logic        hready;
  logic        chr_valid;
  logic [7:0]  chr_data;
  logic        chr_ready;

  modport master (
    output htrans, haddr, hwrite, hwdata, hready, chr_ready,
    input  chr_valid, chr_data
  );

  modport slave (
    input  htrans, haddr, hwrite, hwdata, hready, chr_ready,
    output chr_valid, chr_data
  );
endinterface

// File: rtl/tb_ahb_sim_ctrl.sv
// Simulation controller: decodes CPU writes to the control word into pass/fail/console events.
// Define TB_SIM_CTRL_WDOG_EN to build the no-retire watchdog (HANG state).
module tb_ahb_sim_ctrl #(
  parameter logic [31:0] CTRL_ADDR   = 32'h6000_FFF8,
  parameter int unsigned WDOG_WINDOW = 5000,
  parameter int unsigned FIFO_AW     = 3
) (
  input  logic                clk,
  input  logic                rst_b,
  tb_ahb_sim_ctrl_if.slave    bus,
  input  logic                retire,
  output logic                done,
  output logic                pass,
  output logic                fail,
  output logic                wdog_fail,
  output logic [15:0]         chr_drop_cnt
);

  typedef enum logic [1:0] {S_RUN, S_PASS, S_FAIL, S_HANG} state_t;

  localparam int unsigned DEPTH = 1 << FIFO_AW;
  localparam int unsigned PW    = FIFO_AW + 1;

  state_t state, state_nxt;

  logic          pend;
  logic          addr_ok;
  logic          data_done;
  logic          is_pass;
  logic          is_fail;
  logic          push_req;
  logic          wdog_trip;
  logic          unused_bits;

  logic [7:0]    mem [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic          empty, full, push, pop, drop;

  // Bus snoop: address phase qualifies, data phase completes on the next hready
  assign addr_ok   = bus.hready & bus.htrans[1] & bus.hwrite & (bus.haddr == CTRL_ADDR);
  assign data_done = bus.hready & pend;
  assign is_pass   = (bus.hwdata == 32'h0000_0FFF) || (bus.hwdata == 32'hFFFF_0000);
  assign is_fail   = (bus.hwdata == 32'h0000_0EEE) || (bus.hwdata == 32'hEEEE_0000);

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b)          pend <= 1'b0;
    else if (bus.hready) pend <= addr_ok;
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) state <= S_RUN;
    else        state <= state_nxt;
  end

  // A completing bus write takes priority over a watchdog expiry in the same cycle
  always_comb begin
    state_nxt = state;
    push_req  = 1'b0;
    if (state == S_RUN) begin
      if (data_done && is_pass)      state_nxt = S_PASS;
      else if (data_done && is_fail) state_nxt = S_FAIL;
      else if (wdog_trip)            state_nxt = S_HANG;
      push_req = data_done & ~is_pass & ~is_fail;
    end
  end

  assign pass = (state == S_PASS);
  assign fail = (state == S_FAIL);
  assign done = (state != S_RUN);

  // Console FIFO; a push into a full FIFO survives if the head leaves the same cycle
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[FIFO_AW] != rd_ptr[FIFO_AW]) &&
                 (wr_ptr[FIFO_AW-1:0] == rd_ptr[FIFO_AW-1:0]);
  assign pop   = ~empty & bus.chr_ready;
  assign push  = push_req & (~full | pop);
  assign drop  = push_req & full & ~pop;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[FIFO_AW-1:0]] <= bus.hwdata[7:0];
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      chr_drop_cnt <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      if (drop && (chr_drop_cnt != '1)) chr_drop_cnt <= chr_drop_cnt + 16'd1;
    end
  end

  assign bus.chr_valid = ~empty;
  assign bus.chr_data  = empty ? '0 : mem[rd_ptr[FIFO_AW-1:0]];

`ifdef TB_SIM_CTRL_WDOG_EN
  localparam int unsigned WW = $clog2(WDOG_WINDOW + 1);

  logic [WW-1:0] win_cnt;
  logic          ret_seen;
  logic          win_end;

  assign win_end   = (win_cnt == WW'(WDOG_WINDOW));
  assign wdog_trip = win_end & ~ret_seen & ~retire;
  assign wdog_fail = (state == S_HANG);
  assign unused_bits = bus.htrans[0];

  // Window position runs 1..WDOG_WINDOW; a retire in the closing cycle still counts
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      win_cnt  <= WW'(1);
      ret_seen <= 1'b0;
    end else if (state == S_RUN) begin
      if (win_end) begin
        win_cnt  <= WW'(1);
        ret_seen <= 1'b0;
      end else begin
        win_cnt  <= win_cnt + WW'(1);
        ret_seen <= ret_seen | retire;
      end
    end
  end
`else
  assign wdog_trip   = 1'b0;
  assign wdog_fail   = 1'b0;
  assign unused_bits = ^{bus.htrans[0], retire, WDOG_WINDOW};
`endif

endmodule
